ram_quad_fetch: RTL and testbench

Read sequencer directly downstream of syncRAM. It drives the RAM's four read ports with consecutive byte addresses and captures the four returned bytes. Each group is packed into one 32-bit word and handed to the consumer over a valid/ready handshake, one group per transfer, until the requested group count is exhausted.

---
 rtl/ram_quad_fetch.sv | 126 ++++++++++++
 tb/tb_ram_quad_fetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_quad_fetch.sv
// ram_quad_fetch: reads four consecutive RAM bytes per group and hands the
// packed 32-bit word to a valid/ready consumer until the group count runs out.
module ram_quad_fetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    grp_count,
  output logic                busy,
  output logic                done,
  output logic                ram_cs,
  output logic                ram_rd,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ra_0,
  output logic [ADDR_W-1:0]   ra_1,
  output logic [ADDR_W-1:0]   ra_2,
  output logic [ADDR_W-1:0]   ra_3,
  input  logic [DATA_W-1:0]   dout_0,
  input  logic [DATA_W-1:0]   dout_1,
  input  logic [DATA_W-1:0]   dout_2,
  input  logic [DATA_W-1:0]   dout_3,
  output logic [4*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_HOLD
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cur;
  logic [CNT_W-1:0]    r_rem;
  logic [ADDR_W-1:0]   r_ra0;
  logic [ADDR_W-1:0]   r_ra1;
  logic [ADDR_W-1:0]   r_ra2;
  logic [ADDR_W-1:0]   r_ra3;
  logic [4*DATA_W-1:0] r_data;
  logic                r_valid;
  logic                r_done;

  logic                w_hs;
  logic                w_last;
  logic                w_load;
  logic                w_zero;
  logic                w_enter;
  logic [ADDR_W-1:0]   w_addr;

  assign w_hs    = (r_state == S_HOLD) && r_valid && out_ready;
  assign w_last  = (r_rem == CNT_W'(1));
  assign w_load  = (r_state == S_IDLE) && start && (grp_count != '0);
  assign w_zero  = (r_state == S_IDLE) && start && (grp_count == '0);
  assign w_enter = (w_next == S_ISSUE) && (r_state != S_ISSUE);
  // Address of the group about to be issued: fresh base or next group.
  assign w_addr  = (r_state == S_IDLE) ? base_addr
                                       : r_cur + ADDR_W'(4);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load) w_next = S_ISSUE;
      S_ISSUE: w_next = S_CAPT;
      S_CAPT:  w_next = S_HOLD;
      S_HOLD:  if (w_hs) w_next = w_last ? S_IDLE : S_ISSUE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_rem   <= '0;
      r_ra0   <= '0;
      r_ra1   <= '0;
      r_ra2   <= '0;
      r_ra3   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_zero || (w_hs && w_last);
      if (w_load) begin
        r_cur <= base_addr;
        r_rem <= grp_count;
      end else if (w_hs) begin
        r_cur <= r_cur + ADDR_W'(4);
        r_rem <= r_rem - CNT_W'(1);
      end
      if (w_enter) begin
        r_ra0 <= w_addr;
        r_ra1 <= w_addr + ADDR_W'(1);
        r_ra2 <= w_addr + ADDR_W'(2);
        r_ra3 <= w_addr + ADDR_W'(3);
      end
      if (r_state == S_CAPT) begin
        r_data  <= {dout_3, dout_2, dout_1, dout_0};
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign ram_cs    = (r_state == S_ISSUE);
  assign ram_rd    = (r_state == S_ISSUE);
  assign ram_we    = 1'b0;
  assign ra_0      = r_ra0;
  assign ra_1      = r_ra1;
  assign ra_2      = r_ra2;
  assign ra_3      = r_ra3;
  assign out_data  = r_data;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_ram_quad_fetch.sv
// tb_ram_quad_fetch: scoreboard bench with a behavioural RAM and a
// byte-array reference model for ram_quad_fetch.
module tb_ram_quad_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [6:0]  grp_count = '0;
  logic        busy, done, ram_cs, ram_rd, ram_we;
  logic [7:0]  ra_0, ra_1, ra_2, ra_3;
  logic [7:0]  dout_0 = '0, dout_1 = '0, dout_2 = '0, dout_3 = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] mem [256];

  int  nchecks = 0;
  int  nerrors = 0;
  int  done_cnt = 0;
  int  cs_cnt = 0;
  bit  done_due = 0;
  bit  zc_allow = 0;

  ram_quad_fetch #(.DATA_W(8), .ADDR_W(8), .CNT_W(7)) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .base_addr(base_addr), .grp_count(grp_count),
    .busy(busy), .done(done),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_we(ram_we),
    .ra_0(ra_0), .ra_1(ra_1), .ra_2(ra_2), .ra_3(ra_3),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2), .dout_3(dout_3),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 Clk = ~Clk;

  // syncRAM: one-cycle read latency
  always @(posedge Clk) begin
    if (ram_cs && ram_rd) begin
      dout_0 <= mem[ra_0];
      dout_1 <= mem[ra_1];
      dout_2 <= mem[ra_2];
      dout_3 <= mem[ra_3];
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_model(input logic [7:0] b, input int n);
    logic [7:0] a;
    for (int g = 0; g < n; g++) begin
      a = b + 8'(4 * g);
      addr_q.push_back(a);
      exp_q.push_back('{data: {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)],
                               mem[8'(a + 8'd1)], mem[a]},
                        last: (g == n - 1)});
    end
  endtask

  task automatic push_const(input logic [7:0] a, input logic [31:0] w);
    addr_q.push_back(a);
    exp_q.push_back('{data: w, last: 1'b1});
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done(input bit rnd);
    int d0;
    int t;
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      t++;
    end
    nchecks++;
    if (done_cnt == d0) begin
      nerrors++;
      $display("FAIL done_timeout: no done after %0d cycles", t);
    end
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
  endtask

  task automatic kick(input logic [7:0] b, input int n);
    cyc();
    base_addr = b;
    grp_count = 7'(n);
    start = 1'b1;
    if (n == 0) zc_allow = 1;
    cyc();
    start = 1'b0;
  endtask

  task automatic zero_xfer(input logic [7:0] b);
    int c0;
    c0 = cs_cnt;
    kick(b, 0);
    chk("zc_done", 64'(done), 64'd1);
    chk("zc_busy", 64'(busy), 64'd0);
    cyc();
    chk("zc_done_low", 64'(done), 64'd0);
    chk("zc_no_cs", 64'(cs_cnt - c0), 64'd0);
    zc_allow = 0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 20) begin
      cyc();
      t++;
    end
    chk("valid_seen", 64'(out_valid), 64'd1);
  endtask

  // Monitor: pops the scoreboard on every RAM issue and output handshake
  always @(negedge Clk) begin
    if (!Reset) begin
      if (done_due) chk("done_pulse", 64'(done), 64'd1);
      else if (done && !zc_allow) chk("done_spurious", 64'(done), 64'd0);
      if (done) done_cnt++;
      done_due = 0;
      if (ram_cs) begin
        cs_cnt++;
        chk("ram_rd", 64'(ram_rd), 64'd1);
        chk("ram_we", 64'(ram_we), 64'd0);
        if (addr_q.size() == 0) begin
          chk("unexpected_issue", 64'(ra_0), 64'hxx);
        end else begin
          logic [7:0] a;
          a = addr_q.pop_front();
          chk("ra", {32'(ra_3), 8'(ra_2), 8'(ra_1), 8'(ra_0)},
              {32'(8'(a + 8'd3)), 8'(a + 8'd2), 8'(a + 8'd1), a});
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_data), 64'hxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          done_due = e.last;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cs_rd_we", {ram_cs, ram_rd, ram_we}, 64'd0);
    chk("rst_ra", {ra_3, ra_2, ra_1, ra_0}, 64'd0);
    chk("rst_out", {out_valid, out_data}, 64'd0);
    cyc();
    cyc();
    Reset = 1'b0;

    mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h10;
    mem[3] = 8'h06; mem[4] = 8'h12; mem[5] = 8'h34;
    mem[6] = 8'h56; mem[7] = 8'h78;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB;

    // 1: single group from base 1
    begin
      int c0;
      c0 = cs_cnt;
      out_ready = 1'b1;
      push_const(8'h01, 32'h12061001);
      kick(8'h01, 1);
      wait_done(0);
      chk("t1_one_issue", 64'(cs_cnt - c0), 64'd1);
    end

    // 2: two groups from base 0
    addr_q.push_back(8'h00);
    exp_q.push_back('{data: 32'h06100100, last: 1'b0});
    addr_q.push_back(8'h04);
    exp_q.push_back('{data: 32'h78563412, last: 1'b1});
    kick(8'h00, 2);
    wait_done(0);

    // 3: backpressure holds data and blocks further issue
    begin
      int c0;
      out_ready = 1'b0;
      push_const(8'h01, 32'h12061001);
      kick(8'h01, 1);
      wait_valid();
      c0 = cs_cnt;
      for (int k = 0; k < 5; k++) begin
        cyc();
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_data", 64'(out_data), 64'h12061001);
      end
      chk("bp_no_issue", 64'(cs_cnt - c0), 64'd0);
      wait_done(0);
    end

    // 4: address wrap
    mem[8'h00] = 8'hCC;
    mem[8'h01] = 8'hDD;
    push_const(8'hFE, 32'hDDCCBBAA);
    kick(8'hFE, 1);
    wait_done(0);
    mem[8'h00] = 8'h00;
    mem[8'h01] = 8'h01;

    // 5: zero count
    zero_xfer(8'h40);

    // 6: reset while holding a word
    out_ready = 1'b0;
    push_const(8'h01, 32'h12061001);
    kick(8'h01, 1);
    wait_valid();
    Reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    exp_q.delete();
    addr_q.delete();
    done_due = 0;
    cyc();
    Reset = 1'b0;
    out_ready = 1'b1;
    push_const(8'h01, 32'h12061001);
    kick(8'h01, 1);
    wait_done(0);

    // randomized transfers against the byte-array model
    for (int r = 0; r < 25; r++) begin
      logic [7:0] b;
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      b = 8'($urandom);
      n = (r == 24) ? 70 : $urandom_range(0, 5);
      if (n == 0) begin
        zero_xfer(b);
      end else begin
        push_model(b, n);
        kick(b, n);
        wait_done(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
